frv_wb_ram: RTL and testbench
=============================

# frv_wb_ram

Wishbone classic responder that terminates the core's instruction-memory or data-memory initiator port and converts each transfer into a single-port, synchronous-read SRAM macro access. It sits between a FazyRV macro wrapper (e.g. the 8-bit-chunk core) and an on-chip SRAM. It provides:
- address-range decode;
- byte-enabled writes;
- a configurable number of wait states.

## Interface
Parameters:
- `ADR_W`, default 9: SRAM word-address width (2^ADR_W 32-bit words).
- `BASE_ADR`, default 32'h0000_0000: byte base address of the window; must be 4-byte aligned.
- `WAIT_STATES`, default 0: extra cycles inserted before `wb_ack_o`, range 0..15.

Ports (one clock; reset is asynchronous and active-high):
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `wb_cyc_i`  in  1  bus cycle valid.
- `wb_stb_i`  in  1  transfer strobe.
- `wb_we_i`  in  1  1 = write.
- `wb_be_i`  in  4  byte enables; bit i selects byte i (`dat[8i+7:8i]`).
- `wb_adr_i`  in  32  byte address; bits [1:0] are ignored.
- `wb_dat_i`  in  32  write data.
- `wb_dat_o`  out  32  read data; valid only while `wb_ack_o`=1.
- `wb_ack_o`  out  1  transfer acknowledge; single-cycle pulse.
- `sram_ce_o`  out  1  SRAM chip enable, one-cycle pulse per access.
- `sram_we_o`  out  1  SRAM write enable; qualified by `sram_ce_o`.
- `sram_be_o`  out  4  SRAM byte write mask.
- `sram_adr_o`  out  ADR_W  SRAM word address.
- `sram_dat_o`  out  32  SRAM write data.
- `sram_dat_i`  in  32  SRAM read data, valid the cycle after `sram_ce_o`.

## Operation
- The FSM has four states: `IDLE`, `MEM`, `HOLD`, `ACK`.
- `IDLE`: when `wb_cyc_i & wb_stb_i` is sampled, decode the address as follows.
  - In range means `BASE_ADR <= wb_adr_i < BASE_ADR + 4*2^ADR_W`.
  - Word index = `(wb_adr_i - BASE_ADR) >> 2`, truncated to `ADR_W` bits.
  - In range: register the index, `wb_we_i`, `wb_be_i` and `wb_dat_i`, then go to `MEM`.
  - Out of range: go directly to `ACK` with `wb_dat_o` = 32'h0 and no SRAM access. Writes outside the window are acknowledged and discarded.
- `MEM`: drive `sram_ce_o`=1, `sram_we_o`=we, `sram_adr_o`=index, `sram_dat_o`=wdata.
  - `sram_be_o` = registered `wb_be_i` on a write; 4'h0 on a read.
  - Go to `HOLD` and load the wait counter with `WAIT_STATES`.
- `HOLD`:
  - In the first `HOLD` cycle, capture `sram_dat_i` into the read-data register (reads only).
  - Decrement the counter each cycle. Leave `HOLD` for `ACK` when the counter is 0.
  - `HOLD` therefore lasts 1+`WAIT_STATES` cycles.
- `ACK`: `wb_ack_o`=1 for exactly one cycle and `wb_dat_o` = captured data (0 for writes). Then return to `IDLE`.
- Abort: if `wb_cyc_i` falls while in `MEM` or `HOLD`:
  - The already-issued SRAM operation completes.
  - The FSM returns to `IDLE` on the next edge without asserting `wb_ack_o`.
- A write with `wb_be_i`=4'h0 still runs the full sequence with `sram_be_o`=0 and is acknowledged normally.
- No pipelining: at most one transfer in flight. `wb_stb_i` held high after `ACK` is seen in `IDLE` and starts a new transfer.

## Timing
- Reset (asynchronous, active-high): FSM = `IDLE`, counter = 0, all data and address registers = 0.
- All outputs are 0 during and after reset: `wb_ack_o`, `wb_dat_o`, `sram_ce_o`, `sram_we_o`, `sram_be_o`, `sram_adr_o`, `sram_dat_o`.
- Request sampled in `IDLE` at cycle N:
  - `sram_ce_o` high in cycle N+1.
  - Read data captured at the end of cycle N+2.
  - `wb_ack_o` high in cycle N+3+`WAIT_STATES`, for both reads and writes.
- Out-of-range request sampled at cycle N: `wb_ack_o` high in cycle N+1.
- Outside `MEM`, `sram_ce_o` and `sram_we_o` are 0. `sram_adr_o`, `sram_dat_o` and `sram_be_o` hold their last values.
- Reset asserted mid-transfer: immediate return to `IDLE`, no ack, `sram_ce_o` drops asynchronously.
- `wb_ack_o` is never high for two consecutive cycles.

## Structure
- Package `frv_wb_pkg` holds:
  - the state enum `frv_wb_ram_state_e` (`IDLE`, `MEM`, `HOLD`, `ACK`);
  - `WB_DW`=32;
  - `WB_SELW`=4;
  - `WB_OOR_RDATA`=32'h0.
- Single module with the FSM, the 4-bit wait counter and the range decode. No sub-module is warranted.

## Test plan
- Write then read, `WAIT_STATES`=0, `BASE_ADR`=0:
  - write 32'hCAFE_F00D to 0x10 with be=4'hF;
  - read 0x10 → `wb_dat_o`=32'hCAFE_F00D, ack 3 cycles after the strobe is sampled, `sram_adr_o`=4.
- Byte enables:
  - write 32'hFFFF_FFFF to 0x20;
  - write 32'h0000_AB00 with be=4'b0010;
  - read back → 32'hFFFF_ABFF.
- Wait states, `WAIT_STATES`=3: read → ack at N+6; `wb_ack_o` is a single-cycle pulse.
- Out of range, `BASE_ADR`=32'h4000, `ADR_W`=9:
  - read 0x3FFC → ack at N+1 with data 0 and no `sram_ce_o`;
  - read 0x47FC → in range, `sram_adr_o`=511.
- Abort and reset:
  - drop `wb_cyc_i` in `HOLD` → no ack, and the next request is served normally;
  - assert `rst_i` in `MEM` → all outputs 0 immediately, FSM in `IDLE`.
- Back-to-back: keep `stb` high across 4 sequential reads → 4 acks, each separated by at least one non-ack cycle, with correct data.

Source files
------------

// File: rtl/frv_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : frv_wb_pkg
// Description : Shared types and constants for the FazyRV Wishbone SRAM
//               responder. Holds the responder FSM state encoding and the
//               Wishbone data/select widths.
// Revision    : 1.0 - initial release
// ============================================================================
package frv_wb_pkg;

    // Wishbone data-path width and byte-select width.
    localparam int WB_DW   = 32;
    localparam int WB_SELW = 4;

    // Read data returned for accesses that fall outside the SRAM window.
    localparam logic [WB_DW-1:0] WB_OOR_RDATA = 32'h0000_0000;

    // Responder FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEM  = 2'd1,
        HOLD = 2'd2,
        ACK  = 2'd3
    } frv_wb_ram_state_e;

endpackage : frv_wb_pkg
`default_nettype wire

// File: rtl/frv_wb_ram.sv
`default_nettype none
// ============================================================================
// Module      : frv_wb_ram
// Description : Wishbone classic responder that maps a byte-address window
//               onto a single-port, synchronous-read 32-bit SRAM macro.
//               One transfer in flight at a time; configurable wait states.
//
// Ports
//   clk_i       : clock, rising edge active
//   rst_i       : asynchronous active-high reset
//   wb_cyc_i    : Wishbone bus cycle valid
//   wb_stb_i    : Wishbone transfer strobe
//   wb_we_i     : 1 = write
//   wb_be_i     : byte enables (bit i -> dat[8i+7:8i])
//   wb_adr_i    : byte address, bits [1:0] ignored
//   wb_dat_i    : write data
//   wb_dat_o    : read data, non-zero only while wb_ack_o is high
//   wb_ack_o    : single-cycle transfer acknowledge
//   sram_ce_o   : SRAM chip enable, one-cycle pulse per access
//   sram_we_o   : SRAM write enable, qualified by sram_ce_o
//   sram_be_o   : SRAM byte write mask (0 on reads)
//   sram_adr_o  : SRAM word address
//   sram_dat_o  : SRAM write data
//   sram_dat_i  : SRAM read data, valid the cycle after sram_ce_o
//
// Revision    : 1.0 - initial release
// ============================================================================
module frv_wb_ram
    import frv_wb_pkg::*;
#(
    parameter int          ADR_W       = 9,
    parameter logic [31:0] BASE_ADR    = 32'h0000_0000,
    parameter int          WAIT_STATES = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 wb_cyc_i,
    input  logic                 wb_stb_i,
    input  logic                 wb_we_i,
    input  logic [WB_SELW-1:0]   wb_be_i,
    input  logic [31:0]          wb_adr_i,
    input  logic [WB_DW-1:0]     wb_dat_i,
    output logic [WB_DW-1:0]     wb_dat_o,
    output logic                 wb_ack_o,
    output logic                 sram_ce_o,
    output logic                 sram_we_o,
    output logic [WB_SELW-1:0]   sram_be_o,
    output logic [ADR_W-1:0]     sram_adr_o,
    output logic [WB_DW-1:0]     sram_dat_o,
    input  logic [WB_DW-1:0]     sram_dat_i
);

    // Window size in bytes; 33 bits so a window ending at 2^32 still compares.
    localparam logic [32:0] c_span = 33'd4 << ADR_W;
    localparam logic [3:0]  c_wait = 4'(WAIT_STATES);

    frv_wb_ram_state_e r_state;
    frv_wb_ram_state_e w_state_nxt;

    logic [3:0]         r_cnt;
    logic [ADR_W-1:0]   r_idx;
    logic               r_we;
    logic [WB_SELW-1:0] r_be;
    logic [WB_DW-1:0]   r_wdat;
    logic [WB_DW-1:0]   r_rdat;

    logic               w_req;
    logic [31:0]        w_off;
    logic               w_in_range;
    logic               w_hold_first;

    // ------------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------------
    assign w_req      = wb_cyc_i & wb_stb_i;
    assign w_off      = wb_adr_i - BASE_ADR;
    assign w_in_range = (wb_adr_i >= BASE_ADR) && ({1'b0, w_off} < c_span);

    // The counter is loaded with the wait count on entry to HOLD and only
    // counts down afterwards, so it equals the load value only in the first
    // HOLD cycle - exactly when the SRAM read data is valid.
    assign w_hold_first = (r_state == HOLD) && (r_cnt == c_wait);

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_state_nxt = w_in_range ? MEM : ACK;
                end
            end
            MEM: begin
                // The SRAM access is issued this cycle regardless; an abort
                // only suppresses the acknowledge.
                w_state_nxt = wb_cyc_i ? HOLD : IDLE;
            end
            HOLD: begin
                if (!wb_cyc_i) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == 4'd0) begin
                    w_state_nxt = ACK;
                end
            end
            ACK: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Request capture, wait counter and read-data register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt  <= 4'd0;
            r_idx  <= '0;
            r_we   <= 1'b0;
            r_be   <= '0;
            r_wdat <= '0;
            r_rdat <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        // Writes and out-of-window accesses return this value.
                        r_rdat <= WB_OOR_RDATA;
                        // Out-of-window requests leave the SRAM-facing
                        // registers untouched so the macro pins stay stable.
                        if (w_in_range) begin
                            r_idx  <= w_off[ADR_W+1:2];
                            r_we   <= wb_we_i;
                            r_be   <= wb_we_i ? wb_be_i : '0;
                            r_wdat <= wb_dat_i;
                        end
                    end
                end
                MEM: begin
                    r_cnt <= c_wait;
                end
                HOLD: begin
                    if (w_hold_first && !r_we) begin
                        r_rdat <= sram_dat_i;
                    end
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // Enables decode straight from the state register so that reset removes
    // them asynchronously.
    assign wb_ack_o   = (r_state == ACK);
    assign wb_dat_o   = wb_ack_o ? r_rdat : '0;
    assign sram_ce_o  = (r_state == MEM);
    assign sram_we_o  = sram_ce_o & r_we;
    assign sram_be_o  = r_be;
    assign sram_adr_o = r_idx;
    assign sram_dat_o = r_wdat;

endmodule : frv_wb_ram
`default_nettype wire

// File: tb/tb_frv_wb_ram.sv
`default_nettype none
// ============================================================================
// Module      : tb_frv_wb_ram
// Description : Directed self-checking bench for frv_wb_ram. Two instances:
//               u0 (BASE 0x0, no wait states) and u1 (BASE 0x4000, 3 wait
//               states), each backed by a behavioural synchronous-read SRAM.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_frv_wb_ram;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]        cyc  = '0;
    logic [1:0]        stb  = '0;
    logic [1:0]        we   = '0;
    logic [1:0][3:0]   be   = '0;
    logic [1:0][31:0]  adr  = '0;
    logic [1:0][31:0]  wdat = '0;
    logic [1:0][31:0]  rdat;
    logic [1:0]        ack;
    logic [1:0]        ce;
    logic [1:0]        swe;
    logic [1:0][3:0]   sbe;
    logic [1:0][8:0]   sadr;
    logic [1:0][31:0]  sdo;
    logic [1:0][31:0]  sdi = '0;

    frv_wb_ram #(.ADR_W(9), .BASE_ADR(32'h0000_0000), .WAIT_STATES(0)) u0 (
        .clk_i(clk), .rst_i(rst),
        .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]), .wb_we_i(we[0]), .wb_be_i(be[0]),
        .wb_adr_i(adr[0]), .wb_dat_i(wdat[0]), .wb_dat_o(rdat[0]), .wb_ack_o(ack[0]),
        .sram_ce_o(ce[0]), .sram_we_o(swe[0]), .sram_be_o(sbe[0]),
        .sram_adr_o(sadr[0]), .sram_dat_o(sdo[0]), .sram_dat_i(sdi[0])
    );

    frv_wb_ram #(.ADR_W(9), .BASE_ADR(32'h0000_4000), .WAIT_STATES(3)) u1 (
        .clk_i(clk), .rst_i(rst),
        .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]), .wb_we_i(we[1]), .wb_be_i(be[1]),
        .wb_adr_i(adr[1]), .wb_dat_i(wdat[1]), .wb_dat_o(rdat[1]), .wb_ack_o(ack[1]),
        .sram_ce_o(ce[1]), .sram_we_o(swe[1]), .sram_be_o(sbe[1]),
        .sram_adr_o(sadr[1]), .sram_dat_o(sdo[1]), .sram_dat_i(sdi[1])
    );

    // Behavioural SRAMs: byte-masked write, registered read.
    logic [31:0] mem [2][512];
    int          ce_cnt [2] = '{0, 0};

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (ce[k]) begin
                ce_cnt[k] <= ce_cnt[k] + 1;
                if (swe[k]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (sbe[k][b]) mem[k][sadr[k]][8*b +: 8] <= sdo[k][8*b +: 8];
                    end
                end else begin
                    sdi[k] <= mem[k][sadr[k]];
                end
            end
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete transfer. Entered and left #1 after a rising edge.
    // lat counts rising edges from the request-sampling edge to the ack
    // (-1 on timeout). Also checks that the ack drops the following cycle.
    task automatic xfer(input int k, input logic w, input logic [3:0] b,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output int lat,
                        output logic [8:0] madr, output logic [3:0] mbe,
                        output logic mwe);
        cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; be[k] = b; adr[k] = a; wdat[k] = d;
        lat = -1; rd = 'x; madr = 'x; mbe = 'x; mwe = 'x;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (ce[k]) begin
                madr = sadr[k]; mbe = sbe[k]; mwe = swe[k];
            end
            if (ack[k]) begin
                lat = i; rd = rdat[k];
                break;
            end
        end
        cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0;
        @(posedge clk); #1;
        check("ack_single_pulse", {31'd0, ack[k]}, 32'd0);
    endtask

    logic [31:0] rd;
    int          lat;
    logic [8:0]  madr;
    logic [3:0]  mbe;
    logic        mwe;
    int          ce_before;
    int          n, consec, extra_ack;
    logic        prev_ack;
    logic [31:0] got [4];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check("rst_ack",  {31'd0, ack[k]}, 32'd0);
            check("rst_ce",   {30'd0, ce[k], swe[k]}, 32'd0);
            check("rst_be",   {28'd0, sbe[k]}, 32'd0);
            check("rst_adr",  {23'd0, sadr[k]}, 32'd0);
            check("rst_dato", sdo[k], 32'd0);
            check("rst_dat",  rdat[k], 32'd0);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        // ---------------- u0: write then read ----------------
        xfer(0, 1'b1, 4'hF, 32'h10, 32'hCAFE_F00D, rd, lat, madr, mbe, mwe);
        check("wr_lat",  32'(lat), 32'd3);
        check("wr_dat",  rd, 32'h0);
        check("wr_adr",  {23'd0, madr}, 32'd4);
        check("wr_be",   {28'd0, mbe}, 32'hF);
        check("wr_we",   {31'd0, mwe}, 32'd1);

        xfer(0, 1'b0, 4'hF, 32'h10, 32'h0, rd, lat, madr, mbe, mwe);
        check("rd_lat",  32'(lat), 32'd3);
        check("rd_dat",  rd, 32'hCAFE_F00D);
        check("rd_adr",  {23'd0, madr}, 32'd4);
        check("rd_be",   {28'd0, mbe}, 32'h0);
        check("rd_we",   {31'd0, mwe}, 32'd0);

        // ---------------- u0: byte enables ----------------
        xfer(0, 1'b1, 4'hF, 32'h20, 32'hFFFF_FFFF, rd, lat, madr, mbe, mwe);
        xfer(0, 1'b1, 4'b0010, 32'h20, 32'h0000_AB00, rd, lat, madr, mbe, mwe);
        check("be_mask", {28'd0, mbe}, 32'h2);
        xfer(0, 1'b0, 4'hF, 32'h20, 32'h0, rd, lat, madr, mbe, mwe);
        check("be_rd",   rd, 32'hFFFF_ABFF);

        // zero byte enables: full sequence, ack, nothing written
        xfer(0, 1'b1, 4'h0, 32'h20, 32'h1234_5678, rd, lat, madr, mbe, mwe);
        check("be0_lat", 32'(lat), 32'd3);
        check("be0_be",  {28'd0, mbe}, 32'h0);
        xfer(0, 1'b0, 4'hF, 32'h20, 32'h0, rd, lat, madr, mbe, mwe);
        check("be0_rd",  rd, 32'hFFFF_ABFF);

        // ---------------- u1: out of range / wait states ----------------
        ce_before = ce_cnt[1];
        xfer(1, 1'b0, 4'hF, 32'h3FFC, 32'h0, rd, lat, madr, mbe, mwe);
        check("oor_lo_lat", 32'(lat), 32'd1);
        check("oor_lo_dat", rd, 32'h0);
        check("oor_lo_ce",  32'(ce_cnt[1]), 32'(ce_before));

        xfer(1, 1'b1, 4'hF, 32'h47FC, 32'h5A5A_0001, rd, lat, madr, mbe, mwe);
        check("ws_wr_lat", 32'(lat), 32'd6);
        check("ws_wr_adr", {23'd0, madr}, 32'd511);

        xfer(1, 1'b0, 4'hF, 32'h47FC, 32'h0, rd, lat, madr, mbe, mwe);
        check("ws_rd_lat", 32'(lat), 32'd6);
        check("ws_rd_dat", rd, 32'h5A5A_0001);
        check("ws_rd_adr", {23'd0, madr}, 32'd511);

        ce_before = ce_cnt[1];
        xfer(1, 1'b1, 4'hF, 32'h4800, 32'hDEAD_BEEF, rd, lat, madr, mbe, mwe);
        check("oor_hi_lat", 32'(lat), 32'd1);
        check("oor_hi_ce",  32'(ce_cnt[1]), 32'(ce_before));

        // ---------------- u0: abort in HOLD ----------------
        cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; be[0] = 4'hF; adr[0] = 32'h10;
        @(posedge clk); #1;   // MEM
        @(posedge clk); #1;   // HOLD
        cyc[0] = 1'b0; stb[0] = 1'b0;
        extra_ack = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (ack[0]) extra_ack++;
        end
        check("abort_no_ack", 32'(extra_ack), 32'd0);
        xfer(0, 1'b0, 4'hF, 32'h10, 32'h0, rd, lat, madr, mbe, mwe);
        check("abort_next_lat", 32'(lat), 32'd3);
        check("abort_next_dat", rd, 32'hCAFE_F00D);

        // ---------------- u0: back-to-back reads ----------------
        for (int i = 0; i < 4; i++) begin
            xfer(0, 1'b1, 4'hF, 32'h40 + 32'(4*i), 32'h1111_0000 + 32'(i), rd, lat, madr, mbe, mwe);
        end
        cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; adr[0] = 32'h40;
        n = 0; consec = 0; prev_ack = 1'b0;
        for (int i = 0; i < 60 && n < 4; i++) begin
            @(posedge clk); #1;
            if (ack[0]) begin
                if (prev_ack) consec++;
                got[n] = rdat[0];
                n++;
                adr[0] = 32'h40 + 32'(4*n);
            end
            prev_ack = ack[0];
        end
        cyc[0] = 1'b0; stb[0] = 1'b0;
        check("b2b_count",  32'(n), 32'd4);
        check("b2b_consec", 32'(consec), 32'd0);
        check("b2b_d0", got[0], 32'h1111_0000);
        check("b2b_d1", got[1], 32'h1111_0001);
        check("b2b_d2", got[2], 32'h1111_0002);
        check("b2b_d3", got[3], 32'h1111_0003);
        @(posedge clk); #1;
        @(posedge clk); #1;

        // ---------------- u0: reset during MEM ----------------
        cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; be[0] = 4'hF;
        adr[0] = 32'h30; wdat[0] = 32'h7777_8888;
        @(posedge clk); #1;
        check("mem_ce_before_rst", {31'd0, ce[0]}, 32'd1);
        rst = 1'b1;
        #1;
        check("arst_ce",   {30'd0, ce[0], swe[0]}, 32'd0);
        check("arst_ack",  {31'd0, ack[0]}, 32'd0);
        check("arst_be",   {28'd0, sbe[0]}, 32'd0);
        check("arst_adr",  {23'd0, sadr[0]}, 32'd0);
        check("arst_dato", sdo[0], 32'd0);
        check("arst_dat",  rdat[0], 32'd0);
        cyc[0] = 1'b0; stb[0] = 1'b0; we[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        xfer(0, 1'b0, 4'hF, 32'h10, 32'h0, rd, lat, madr, mbe, mwe);
        check("post_rst_lat", 32'(lat), 32'd3);
        check("post_rst_dat", rd, 32'hCAFE_F00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_frv_wb_ram
`default_nettype wire
